// File: rtl/sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// sram_access_sequencer
//   Timing controller for a 256-row 6T SRAM macro. Accepts one single-beat
//   read or write request at a time and sequences the macro's analog strobes
//   through PRECHARGE -> WORDLINE -> (SENSE, reads only) -> DONE, each phase
//   lasting a programmable number of clocks. Read data is returned with a
//   one-cycle rsp_valid pulse.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both 1. req_ready is 1 only in IDLE, so at most one access
//   is in flight; req_valid/req_* are ignored outside IDLE and an access
//   always completes once accepted.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_we/req_addr/req_wdata request: 1=write, row address, write data
//   rsp_valid/rsp_rdata      one-cycle read-data pulse, held read data
//   busy                     access in progress (any state but IDLE)
//   pre_en/wl_en             bitline precharge, global wordline enable
//   row_addr                 registered row address to the decoder
//   write_en/sense_en        write driver and sense amp strobes
//   wd_drive                 write driver data (BL side)
//   sa_data                  sense amp outputs from the macro
//   dbg_state                current FSM state for observation
// -----------------------------------------------------------------------------
module sram_access_sequencer #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 128,
   parameter int PRE_CYC   = 1,
   parameter int WL_CYC    = 2,
   parameter int SENSE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              pre_en,
   output logic              wl_en,
   output logic [ADDR_W-1:0] row_addr,
   output logic              write_en,
   output logic              sense_en,
   output logic [DATA_W-1:0] wd_drive,
   input  logic [DATA_W-1:0] sa_data,
   output logic [2:0]        dbg_state
);

   localparam int MAX_CYC = (PRE_CYC > WL_CYC) ?
                            ((PRE_CYC > SENSE_CYC) ? PRE_CYC : SENSE_CYC) :
                            ((WL_CYC  > SENSE_CYC) ? WL_CYC  : SENSE_CYC);
   localparam int CNT_W = $clog2(MAX_CYC + 1);

   // Counters load length-1 and advance on reaching 0, so a length of 1
   // gives a single-cycle phase and the counter never wraps.
   localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] WL_LD    = CNT_W'(WL_CYC - 1);
   localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PRECHARGE = 3'd1,
      S_WORDLINE  = 3'd2,
      S_SENSE     = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_we;

   assign dbg_state = r_state;

   // All strobes are registered: each is set on the edge that enters the
   // phase it belongs to, so the macro only ever sees clean edge-aligned
   // transitions. Reset drops wl_en/write_en/sense_en asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         req_ready <= 1'b1;
         pre_en    <= 1'b1;
         wl_en     <= 1'b0;
         write_en  <= 1'b0;
         sense_en  <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
         row_addr  <= '0;
         wd_drive  <= '0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // req_ready is always 1 here, so req_valid alone accepts.
               if (req_valid) begin
                  r_state   <= S_PRECHARGE;
                  r_cnt     <= PRE_LD;
                  r_we      <= req_we;
                  row_addr  <= req_addr;
                  wd_drive  <= req_wdata;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_PRECHARGE: begin
               if (r_cnt == '0) begin
                  r_state  <= S_WORDLINE;
                  r_cnt    <= WL_LD;
                  pre_en   <= 1'b0;
                  wl_en    <= 1'b1;
                  write_en <= r_we;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_WORDLINE: begin
               if (r_cnt == '0) begin
                  if (r_we) begin
                     r_state  <= S_DONE;
                     wl_en    <= 1'b0;
                     write_en <= 1'b0;
                     pre_en   <= 1'b1;
                  end else begin
                     // Wordline stays up through sensing so the cells keep
                     // driving the bitline differential.
                     r_state  <= S_SENSE;
                     r_cnt    <= SENSE_LD;
                     sense_en <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_SENSE: begin
               if (r_cnt == '0) begin
                  r_state   <= S_DONE;
                  rsp_rdata <= sa_data;
                  rsp_valid <= 1'b1;
                  wl_en     <= 1'b0;
                  sense_en  <= 1'b0;
                  pre_en    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               pre_en    <= 1'b1;
               wl_en     <= 1'b0;
               write_en  <= 1'b0;
               sense_en  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_access_sequencer
//   Directed bench for sram_access_sequencer. Instance dut uses default phase
//   lengths and sits on a behavioural macro array; instance dut2 uses
//   PRE/WL/SENSE = 3/4/2 with a fixed sense-amp pattern. Outputs are sampled
//   1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sram_access_sequencer;

   localparam int AW = 8;
   localparam int DW = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance 1 (defaults) ----------------
   logic          req_valid = 1'b0, req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready, rsp_valid, busy, pre_en, wl_en, write_en, sense_en;
   logic [DW-1:0] rsp_rdata, wd_drive, sa_data;
   logic [AW-1:0] row_addr;
   logic [2:0]    dbg_state;

   sram_access_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .pre_en(pre_en), .wl_en(wl_en), .row_addr(row_addr),
      .write_en(write_en), .sense_en(sense_en), .wd_drive(wd_drive),
      .sa_data(sa_data), .dbg_state(dbg_state)
   );

   // Behavioural macro: array written while wordline+write_en, read via SA.
   logic [DW-1:0] macro_mem [256];
   always @(posedge clk)
      if (wl_en && write_en) macro_mem[row_addr] <= wd_drive;
   assign sa_data = sense_en ? macro_mem[row_addr] : '0;

   // ---------------- instance 2 (3/4/2) ----------------
   localparam logic [DW-1:0] SA2_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   logic          req_valid2 = 1'b0, req_we2 = 1'b0;
   logic [AW-1:0] req_addr2 = '0;
   logic [DW-1:0] req_wdata2 = '0;
   logic          req_ready2, rsp_valid2, busy2, pre_en2, wl_en2, write_en2, sense_en2;
   logic [DW-1:0] rsp_rdata2, wd_drive2, sa_data2;
   logic [AW-1:0] row_addr2;
   logic [2:0]    dbg_state2;

   sram_access_sequencer #(.PRE_CYC(3), .WL_CYC(4), .SENSE_CYC(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
      .req_addr(req_addr2), .req_wdata(req_wdata2),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
      .pre_en(pre_en2), .wl_en(wl_en2), .row_addr(row_addr2),
      .write_en(write_en2), .sense_en(sense_en2), .wd_drive(wd_drive2),
      .sa_data(sa_data2), .dbg_state(dbg_state2)
   );
   assign sa_data2 = sense_en2 ? SA2_PAT : '0;

   // ---------------- scoreboard state ----------------
   int            n_checks = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_mem [256];
   logic [DW-1:0] last_rd = '0;
   logic [DW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observed strobe vector {pre,wl,we,se,ready,busy,rsp_valid}.
   function automatic logic [6:0] obs(input bit sel);
      if (sel) return {pre_en2, wl_en2, write_en2, sense_en2, req_ready2, busy2, rsp_valid2};
      return {pre_en, wl_en, write_en, sense_en, req_ready, busy, rsp_valid};
   endfunction

   // Expected strobe vector n cycles after the accept cycle.
   function automatic logic [6:0] exp_vec(input bit we, input int n,
                                          input int p, input int w, input int s);
      int done_n;
      done_n = we ? (p + w + 1) : (p + w + s + 1);
      if (n <= p)                    return 7'b1000010;
      if (n <= p + w)                return we ? 7'b0110010 : 7'b0100010;
      if (!we && n <= p + w + s)     return 7'b0101010;
      if (n == done_n)               return we ? 7'b1000010 : 7'b1000011;
      return 7'b1000100;
   endfunction

   // One access: drive request (current cycle = accept cycle), then check
   // every following cycle up to and including the IDLE cycle after DONE.
   task automatic run_access(input bit sel, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input bit hold, input string tag);
      int p, w, s, last_n;
      logic [DW-1:0] exp_rd;
      p = sel ? 3 : 1;  w = sel ? 4 : 2;  s = sel ? 2 : 1;
      last_n = we ? (p + w + 2) : (p + w + s + 2);
      if (sel) begin
         req_valid2 = 1'b1; req_we2 = we; req_addr2 = addr; req_wdata2 = data;
         exp_rd = SA2_PAT;
      end else begin
         req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
         exp_rd = exp_mem[addr];
         if (we) exp_mem[addr] = data;
      end
      if (!we) exp_q.push_back(exp_rd);
      for (int n = 1; n <= last_n; n++) begin
         step();
         if (n == 1 && !hold) begin
            if (sel) req_valid2 = 1'b0; else req_valid = 1'b0;
         end
         check({tag, "_strobes"}, DW'(obs(sel)), DW'(exp_vec(we, n, p, w, s)));
         if (n > p && n <= last_n - 2)
            check({tag, "_row_addr"}, DW'(sel ? row_addr2 : row_addr), DW'(addr));
         if (we && n > p && n <= p + w)
            check({tag, "_wd_drive"}, sel ? wd_drive2 : wd_drive, data);
         if (!we && n == last_n - 1) begin
            last_rd = exp_q.pop_front();
            check({tag, "_rdata"}, sel ? rsp_rdata2 : rsp_rdata, last_rd);
         end else if (!sel && (we || n < last_n - 1)) begin
            check({tag, "_rdata_hold"}, rsp_rdata, last_rd);
         end
      end
   endtask

   // ---------------- invariant monitor ----------------
   logic          prev_wl = 1'b0, prev_wl2 = 1'b0;
   logic [AW-1:0] prev_row = '0, prev_row2 = '0;
   always @(negedge clk) begin
      check("inv_we_se",   DW'(write_en & sense_en), '0);
      check("inv_strobe_wl", DW'((write_en | sense_en) & ~wl_en), '0);
      check("inv_pre_wl",  DW'(pre_en & wl_en), '0);
      if (wl_en && prev_wl) check("inv_row_stable", DW'(row_addr), DW'(prev_row));
      check("inv2_we_se",  DW'(write_en2 & sense_en2), '0);
      check("inv2_strobe_wl", DW'((write_en2 | sense_en2) & ~wl_en2), '0);
      check("inv2_pre_wl", DW'(pre_en2 & wl_en2), '0);
      if (wl_en2 && prev_wl2) check("inv2_row_stable", DW'(row_addr2), DW'(prev_row2));
      prev_wl  = wl_en;  prev_row  = row_addr;
      prev_wl2 = wl_en2; prev_row2 = row_addr2;
   end

   // ---------------- main sequence ----------------
   logic [DW-1:0] d_a5, d1, d2, rd;
   bit            rwe;
   logic [AW-1:0] raddr;

   initial begin
      for (int i = 0; i < 256; i++) begin
         macro_mem[i] = '0;
         exp_mem[i]   = '0;
      end
      d_a5 = {16{8'hA5}};
      d1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      d2   = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_FACE_B00C;

      // Reset values while rst_n is held low.
      rst_n = 1'b0;
      step();
      check("rst_strobes", DW'(obs(0)), DW'(7'b1000100));
      check("rst_state", DW'(dbg_state), '0);
      check("rst_row_addr", DW'(row_addr), '0);
      check("rst_wd_drive", wd_drive, '0);
      check("rst_rdata", rsp_rdata, '0);
      check("rst2_strobes", DW'(obs(1)), DW'(7'b1000100));
      rst_n = 1'b1;

      // Idle for 10 clocks.
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_strobes", DW'(obs(0)), DW'(7'b1000100));
      end

      // Write 0x3C then read it back.
      run_access(0, 1'b1, 8'h3C, d_a5, 1'b0, "wr3c");
      step();
      run_access(0, 1'b0, 8'h3C, '0, 1'b0, "rd3c");

      // req_valid held high, alternating write/read on 0x00/0xFF.
      run_access(0, 1'b1, 8'h00, d1, 1'b1, "alt_w00");
      run_access(0, 1'b0, 8'hFF, '0, 1'b1, "alt_rff");
      run_access(0, 1'b1, 8'hFF, d2, 1'b1, "alt_wff");
      run_access(0, 1'b0, 8'h00, '0, 1'b1, "alt_r00");
      run_access(0, 1'b0, 8'hFF, '0, 1'b1, "alt_rff2");
      req_valid = 1'b0;
      step();
      check("after_alt_idle", DW'(obs(0)), DW'(7'b1000100));

      // Random requests, scoreboarded against exp_mem.
      for (int i = 0; i < 1000; i++) begin
         rwe   = ($urandom_range(0, 1) == 1);
         raddr = AW'($urandom_range(0, 15));
         rd    = {$urandom, $urandom, $urandom, $urandom};
         run_access(0, rwe, raddr, rd, ($urandom_range(0, 1) == 1), "rnd");
      end
      req_valid = 1'b0;
      step();

      // Long-phase instance: read with 3/4/2 phases, rsp_valid at accept+10.
      run_access(1, 1'b0, 8'h55, '0, 1'b0, "p342_rd");
      run_access(1, 1'b1, 8'hAA, d1, 1'b0, "p342_wr");

      // Reset asserted during the wordline phase of a write.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h77; req_wdata = d2;
      step();
      req_valid = 1'b0;
      step();
      check("abort_in_wl", DW'(obs(0)), DW'(7'b0110010));
      rst_n = 1'b0;
      #1;
      check("abort_drop", DW'({wl_en, write_en, sense_en}), DW'(3'b000));
      check("abort_pre", DW'({pre_en, req_ready, busy}), DW'(3'b110));
      step();
      rst_n = 1'b1;
      last_rd = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("abort_idle", DW'(obs(0)), DW'(7'b1000100));
         check("abort_state", DW'(dbg_state), '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
